// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: font table, blank code, segment
// indices and the capture state enum.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; entry n is hex digit n
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_hex_capture_if.sv
// Segment bus in, decoded digit and error counters out.
// The master drives the bus; the capture block is the slave.
interface seg7_hex_capture_if #(
  parameter int ERR_W = 8
);

  logic [6:0]       seg_in;
  logic             clr_err;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             have_digit;
  logic             blank;
  logic [ERR_W-1:0] bad_pat_cnt;
  logic [ERR_W-1:0] seq_err_cnt;

  modport master (
    output seg_in, clr_err,
    input  digit, digit_valid, have_digit,
    input  blank, bad_pat_cnt, seq_err_cnt
  );

  modport slave (
    input  seg_in, clr_err,
    output digit, digit_valid, have_digit,
    output blank, bad_pat_cnt, seq_err_cnt
  );

endinterface

// File: rtl/seg7_font_decode.sv
// Combinational 7-segment pattern to hex digit decoder.
// valid_o is set only for one of the 16 font patterns.
module seg7_font_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       valid_o,
  output logic       blank_o,
  output logic [3:0] digit_o
);

  always_comb begin
    valid_o = 1'b0;
    digit_o = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pat_i == FONT[i]) begin
        valid_o = 1'b1;
        digit_o = 4'(i);
      end
    end
  end

  assign blank_o = (pat_i == BLANK);

endmodule

// File: rtl/seg7_hex_capture.sv
// Samples and debounces a 7-segment bus, decodes the digit and
// checks that digits form a mod-16 up-count or a clear to 0.
module seg7_hex_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 0,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  seg7_hex_capture_if.slave  bus
);

  localparam logic [3:0] N = 4'(STABLE_CYCLES);

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       prev_q, last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             dv_q, dv_d;
  logic             have_q, have_d;
  logic             blank_q, blank_d;
  logic [ERR_W-1:0] bad_q, bad_d;
  logic [ERR_W-1:0] seq_q, seq_d;

  logic [6:0] s;
  logic       same, accept;
  logic       bad_inc, seq_inc;
  logic       dec_valid, dec_blank;
  logic [3:0] dec_digit;

  assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign same = (s == prev_q);
  // Fires only on the cycle the run first hits N
  assign accept = same && (cnt_q == N - 4'd1)
               && (s != last_q);

  seg7_font_decode u_dec (
    .pat_i   (s),
    .valid_o (dec_valid),
    .blank_o (dec_blank),
    .digit_o (dec_digit)
  );

  always_comb begin
    cnt_d = 4'd1;
    if (same) begin
      cnt_d = (cnt_q == N) ? cnt_q : cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    have_d  = have_q;
    blank_d = blank_q;
    last_d  = last_q;
    bad_inc = 1'b0;
    seq_inc = 1'b0;
    if (accept) begin
      last_d = s;
      unique case (1'b1)
        dec_valid: begin
          digit_d = dec_digit;
          dv_d    = 1'b1;
          have_d  = 1'b1;
          blank_d = 1'b0;
          state_d = LOCKED;
          if (state_q == LOCKED
              && dec_digit != digit_q + 4'd1
              && dec_digit != 4'd0)
            seq_inc = 1'b1;
        end
        dec_blank: begin
          blank_d = 1'b1;
          have_d  = 1'b0;
          state_d = EMPTY;
        end
        default: begin
          bad_inc = 1'b1;
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Clear has priority over a same-cycle increment
  always_comb begin
    bad_d = bad_q;
    seq_d = seq_q;
    if (bus.clr_err) begin
      bad_d = '0;
      seq_d = '0;
    end else begin
      if (bad_inc && bad_q != '1) bad_d = bad_q + 1'b1;
      if (seq_inc && seq_q != '1) seq_d = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      state_q <= EMPTY;
      digit_q <= '0;
      dv_q    <= 1'b0;
      have_q  <= 1'b0;
      blank_q <= 1'b1;
      bad_q   <= '0;
      seq_q   <= '0;
    end else begin
      sync1_q <= bus.seg_in;
      sync2_q <= sync1_q;
      prev_q  <= s;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      state_q <= state_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      have_q  <= have_d;
      blank_q <= blank_d;
      bad_q   <= bad_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = dv_q;
  assign bus.have_digit  = have_q;
  assign bus.blank       = blank_q;
  assign bus.bad_pat_cnt = bad_q;
  assign bus.seq_err_cnt = seq_q;

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Bench for seg7_hex_capture: an active-high ERR_W=8 instance and an
// active-low ERR_W=2 instance fed the same logical patterns.
module tb_seg7_hex_capture;

  localparam int NST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [6:0] seg = 7'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_hex_capture_if #(.ERR_W(8)) ifa ();
  seg7_hex_capture_if #(.ERR_W(2)) ifb ();

  assign ifa.seg_in  = seg;
  assign ifa.clr_err = clr;
  assign ifb.seg_in  = ~seg;
  assign ifb.clr_err = clr;

  seg7_hex_capture #(
    .STABLE_CYCLES(NST), .ACTIVE_LOW(0), .ERR_W(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  seg7_hex_capture #(
    .STABLE_CYCLES(NST), .ACTIVE_LOW(1), .ERR_W(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [6:0] FT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int font_idx(input logic [6:0] p);
    int r = -1;
    for (int k = 0; k < 16; k++) if (FT[k] == p) r = k;
    return r;
  endfunction

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Spec-level model: raw samples delayed two edges form s;
  // a run of NST equal s values accepts s once.
  logic [6:0] m_p1 [2] = '{7'h0, 7'h0};
  logic [6:0] m_p2 [2] = '{7'h0, 7'h0};
  logic [6:0] m_prev [2] = '{7'h0, 7'h0};
  logic [6:0] m_last [2] = '{7'h0, 7'h0};
  int   m_cnt [2] = '{0, 0};
  int   m_dig [2] = '{0, 0};
  bit   m_dv [2] = '{0, 0};
  bit   m_have [2] = '{0, 0};
  bit   m_blank [2] = '{1, 1};
  bit   m_lock [2] = '{0, 0};
  int   m_bad [2] = '{0, 0};
  int   m_seq [2] = '{0, 0};
  int   m_max [2] = '{255, 3};
  logic [6:0] ms, mraw;
  int   mold, midx;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mraw = (i == 1) ? ~seg : seg;
      if (rst) begin
        m_p1[i] = 0; m_p2[i] = 0; m_prev[i] = 0;
        m_last[i] = 0; m_cnt[i] = 0; m_dig[i] = 0;
        m_dv[i] = 0; m_have[i] = 0; m_blank[i] = 1;
        m_lock[i] = 0; m_bad[i] = 0; m_seq[i] = 0;
      end else begin
        ms = (i == 1) ? ~m_p2[i] : m_p2[i];
        mold = m_cnt[i];
        if (ms == m_prev[i])
          m_cnt[i] = (mold < NST) ? mold + 1 : NST;
        else
          m_cnt[i] = 1;
        m_prev[i] = ms;
        m_p2[i] = m_p1[i];
        m_p1[i] = mraw;
        m_dv[i] = 0;
        if (m_cnt[i] == NST && mold != NST && ms != m_last[i]) begin
          m_last[i] = ms;
          midx = font_idx(ms);
          if (midx >= 0) begin
            if (m_lock[i] && midx != (m_dig[i] + 1) % 16
                && midx != 0 && m_seq[i] < m_max[i])
              m_seq[i]++;
            m_dig[i] = midx;
            m_dv[i] = 1; m_have[i] = 1;
            m_blank[i] = 0; m_lock[i] = 1;
          end else if (ms == 7'h00) begin
            m_blank[i] = 1; m_have[i] = 0; m_lock[i] = 0;
          end else begin
            if (m_bad[i] < m_max[i]) m_bad[i]++;
            m_lock[i] = 0;
          end
        end
        if (clr) begin
          m_bad[i] = 0;
          m_seq[i] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("a_digit", int'(ifa.digit), m_dig[0]);
    chk("a_dv", int'(ifa.digit_valid), int'(m_dv[0]));
    chk("a_have", int'(ifa.have_digit), int'(m_have[0]));
    chk("a_blank", int'(ifa.blank), int'(m_blank[0]));
    chk("a_bad", int'(ifa.bad_pat_cnt), m_bad[0]);
    chk("a_seq", int'(ifa.seq_err_cnt), m_seq[0]);
    chk("b_digit", int'(ifb.digit), m_dig[1]);
    chk("b_dv", int'(ifb.digit_valid), int'(m_dv[1]));
    chk("b_have", int'(ifb.have_digit), int'(m_have[1]));
    chk("b_blank", int'(ifb.blank), int'(m_blank[1]));
    chk("b_bad", int'(ifb.bad_pat_cnt), m_bad[1]);
    chk("b_seq", int'(ifb.seq_err_cnt), m_seq[1]);
  end

  int pulses, first, tot;

  task automatic hold(input logic [6:0] p, input int n);
    @(negedge clk);
    seg = p;
    pulses = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (ifa.digit_valid) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_digit", int'(ifa.digit), 0);
    chk("rst_have", int'(ifa.have_digit), 0);
    chk("rst_blank", int'(ifa.blank), 1);
    chk("rst_bad", int'(ifa.bad_pat_cnt), 0);

    hold(7'h3F, 10);
    chk("first_edge", first, 6);
    chk("first_pulses", pulses, 1);
    chk("first_digit", int'(ifa.digit), 0);
    chk("first_have", int'(ifa.have_digit), 1);
    chk("first_blank", int'(ifa.blank), 0);

    tot = 0;
    for (int d = 1; d <= 16; d++) begin
      hold(FT[d % 16], 8);
      tot += pulses;
    end
    chk("count_pulses", tot, 16);
    chk("count_seq", int'(ifa.seq_err_cnt), 0);
    chk("count_digit", int'(ifa.digit), 0);

    hold(7'h06, 8);
    hold(7'h4F, 8);
    chk("skip_seq", int'(ifa.seq_err_cnt), 1);
    chk("skip_digit", int'(ifa.digit), 3);
    hold(7'h00, 8);
    chk("blank_blank", int'(ifa.blank), 1);
    chk("blank_have", int'(ifa.have_digit), 0);
    chk("blank_digit", int'(ifa.digit), 3);
    hold(7'h66, 8);
    chk("after_blank_digit", int'(ifa.digit), 4);
    chk("after_blank_seq", int'(ifa.seq_err_cnt), 1);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_seq", int'(ifa.seq_err_cnt), 0);

    hold(7'h00, 8);
    hold(7'h06, 8);
    tot = 0;
    for (int g = 0; g < 2; g++) begin
      hold(7'h7F, 3);
      tot += pulses;
      hold(7'h06, 5);
      tot += pulses;
    end
    chk("glitch_pulses", tot, 0);
    chk("glitch_digit", int'(ifa.digit), 1);
    hold(7'h7F, 8);
    chk("eight_pulses", pulses, 1);
    chk("eight_digit", int'(ifa.digit), 8);
    chk("eight_seq", int'(ifa.seq_err_cnt), 1);

    hold(7'h55, 8);
    chk("bad_pulses", pulses, 0);
    chk("bad_cnt_a", int'(ifa.bad_pat_cnt), 1);
    hold(7'h5B, 8);
    chk("relock_digit", int'(ifa.digit), 2);
    chk("relock_seq", int'(ifa.seq_err_cnt), 1);

    for (int b = 0; b < 5; b++) hold((b % 2 == 0) ? 7'h2A : 7'h55, 8);
    chk("bad6_a", int'(ifa.bad_pat_cnt), 6);
    chk("bad_sat_b", int'(ifb.bad_pat_cnt), 3);

    @(negedge clk);
    seg = 7'h55;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_win_a", int'(ifa.bad_pat_cnt), 0);
    chk("clr_win_b", int'(ifb.bad_pat_cnt), 0);
    @(negedge clk);
    clr = 1'b0;

    hold(7'h6D, 3);
    chk("pre_rst_pulses", pulses, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (ifa.digit_valid && first == 0) first = k;
    end
    chk("post_rst_edge", first, 6);
    chk("post_rst_digit_a", int'(ifa.digit), 5);
    chk("post_rst_digit_b", int'(ifb.digit), 5);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_hex_capture.md
Name: seg7_hex_capture

Overview:
- Receive side of the team's hex 7-segment display path: samples a 7-segment bus, debounces it, decodes each segment pattern back to a 4-bit hex digit, and checks that successive digits form a mod-16 up-count or a clear to 0.
- Sits in front of self-test and loopback logic to verify counter/display blocks from their segment pins alone.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples needed to accept a pattern (legal range 2..15).
- ACTIVE_LOW, 0, 1 = inputs are active-low segments; inverted immediately after synchronization.
- ERR_W, 8, width of each saturating error counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, bit0 = a; asynchronous to clk.
- clr_err  in  1  synchronous clear of both error counters.
- digit  out  4  last accepted valid digit.
- digit_valid  out  1  one-cycle pulse when a valid digit is accepted.
- have_digit  out  1  high once any valid digit has been accepted since reset or blank.
- blank  out  1  high while the last accepted pattern is 0x00.
- bad_pat_cnt  out  ERR_W  accepted patterns not in the font (saturating).
- seq_err_cnt  out  ERR_W  out-of-sequence digits (saturating).

Behaviour:
- Reset values: digit=0, digit_valid=0, have_digit=0, blank=1, both counters=0, synchronizer=0, stable_cnt=0, state=EMPTY.
- Synchronizer: two flops on seg_in, then inversion when ACTIVE_LOW=1 (the result is sample s).
- Stability counter:
  - When s equals the previous s, stable_cnt increments, saturating at STABLE_CYCLES; otherwise it reloads to 1.
  - Acceptance fires on the cycle stable_cnt first reaches STABLE_CYCLES, and only if s differs from the last accepted pattern. An unchanged pattern is never re-accepted.
  - The first pattern after reset is compared against reset value 0x00, so an all-off bus is not accepted.
- Latency: a clean step on seg_in raises digit_valid on the (STABLE_CYCLES+2)th rising edge after the step (6 edges for the default).
- Font (active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. 0x00 means blank. Anything else is bad.
- State machine: EMPTY (no reference digit) and LOCKED (reference = digit).
- On acceptance:
  - Valid digit in EMPTY: load digit, pulse digit_valid, set have_digit, clear blank, go to LOCKED. No sequence check.
  - Valid digit in LOCKED: load digit and pulse digit_valid. If the new value is neither (digit+1) mod 16 nor 0, increment seq_err_cnt. F->0 is legal wrap; any ->0 is legal clear. Stay LOCKED.
  - Blank: set blank, clear have_digit, go to EMPTY. digit holds its value. No error.
  - Bad pattern: increment bad_pat_cnt, go to EMPTY. digit, have_digit and blank hold.
- Error counters saturate at 2^ERR_W-1.
- Simultaneous clr_err and an increment: clr_err wins and the counter becomes 0.
- rst asserted at any time, including mid-stability: all state returns to reset values immediately. The first acceptance after release follows the same latency as above.
- Glitches shorter than STABLE_CYCLES synchronized cycles are ignored and do not disturb the last accepted pattern.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry font constant array and the BLANK constant.
  - Segment bit-index constants.
  - EMPTY/LOCKED state enum.
  - The package is reused by the existing display driver.
- Sub-module seg7_font_decode: combinational 7-bit pattern to {valid, is_blank, digit[3:0]}. Exhaustively unit-testable.
- The synchronizer, stability logic, FSM and counters stay in the top module.

Test Plan:
- Reset then hold 0x3F for 10 cycles -> digit_valid pulses once, on edge 6 after the step; digit=0, have_digit=1, blank=0, counters 0.
- Step 0x06, 0x5B, ..., 0x71, 0x3F, each held 8 cycles -> 16 pulses with digits 1..F then 0; seq_err_cnt=0 (F->0 wrap legal).
- Sequence 3F, 06, 4F (0->1->3), each held 8 cycles -> seq_err_cnt=1, digit=3. Then blank 0x00 and 66 (4) -> no further error, since 4 follows a blank.
- Hold 0x06; insert 3-cycle glitches to 0x7F -> no extra digit_valid, digit stays 1. Hold 0x7F for 4+ cycles -> one pulse, digit=8, seq_err_cnt=1.
- Apply 0x55 (bad) for 8 cycles -> bad_pat_cnt=1, no pulse. Then 0x5B -> digit=2, no sequence error (state EMPTY). Finally, with ERR_W=2 and 5 bad patterns, bad_pat_cnt saturates at 3; clr_err coincident with a 6th bad acceptance -> 0.
- ACTIVE_LOW=1: drive ~0x6D, and assert rst for 1 cycle after 3 stable cycles -> no pulse before reset; after release the pulse arrives 6 edges later with digit=5.
